matrix_row_sequencer: RTL and testbench
=======================================

# matrix_row_sequencer

Row-streaming controller for the matrix coprocessor's element-wise row operators, such as the row negation stage. On a start pulse it reads a ROWS-row matrix from the source buffer, one packed row per cycle. It presents each row to the operator on `op_row`, waits a fixed operator latency, and writes each result row into the destination buffer at the same row index. It then pulses `done`. It sits between the matrix register banks and any single-cycle or pipelined row operator.

## Interface
- ROWS, 5: number of rows streamed per operation (1..8).
- ROW_W, 40: packed row width (5 signed 8-bit elements, element 0 in [ROW_W-1:ROW_W-8]).
- OP_LAT, 1: cycles from `op_row` change to the matching `op_res` (registered operator = 1; valid 1..4).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- src_rd  out  1  source read strobe.
- src_addr  out  3  source row index.
- src_rdata  in  ROW_W  source row, valid the cycle after `src_rd` (synchronous memory, 1-cycle read).
- op_row  out  ROW_W  registered row to operator.
- op_res  in  ROW_W  operator result row.
- dst_we  out  1  destination write strobe.
- dst_addr  out  3  destination row index.
- dst_wdata  out  ROW_W  destination row data.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE -> ISSUE when `start`=1 at a rising edge.
- ISSUE:
  - `src_rd`=1 with `src_addr`=0..ROWS-1, one per cycle, no gaps.
  - After index ROWS-1 is issued -> DRAIN.
- DRAIN: issues no reads. Goes to DONE on the cycle the write for row ROWS-1 is performed.
- DONE: `done`=1 for exactly one cycle, then -> IDLE.
- Tag pipeline: a valid bit plus 3-bit row index per stage tracks every row through the three steps below.
  - Read issue.
  - `op_row` capture, which is `src_rdata` registered the cycle after issue.
  - OP_LAT operator delay, after which `op_res` is registered into `dst_wdata`/`dst_addr` with `dst_we`=1.
- `dst_wdata` is `op_res` unmodified. The sequencer performs no arithmetic; widths pass through at ROW_W.
- `op_row` holds its last captured value when idle. `dst_we` is high only for tagged valid rows: exactly ROWS write pulses per operation, indices 0..ROWS-1 in ascending order.
- `start` in ISSUE, DRAIN or DONE is ignored and is not queued.
- Reset asserted mid-operation:
  - All state and outputs clear immediately.
  - Pending tags are discarded and no further writes occur.
  - After release the block is in IDLE and requires a new `start`.

## Timing
- Reset values: `src_rd`=0, `src_addr`=0, `op_row`=0, `dst_we`=0, `dst_addr`=0, `dst_wdata`=0, `busy`=0, `done`=0.
- With `start` sampled at edge 0, cycle 1 is the first cycle after that edge.
- `src_rd` is high in cycles 1..ROWS with `src_addr`=c-1.
- Row i is read in cycle i+1 and appears on `op_row` in cycle i+3.
- `op_res` for row i is valid in cycle i+3+OP_LAT.
- `dst_we` for row i is high in cycle i+4+OP_LAT.
- Last write is in cycle ROWS+3+OP_LAT. `done` is in cycle ROWS+4+OP_LAT (10 with defaults).
- `busy`=1 in cycles 1..ROWS+3+OP_LAT, and is 0 in the `done` cycle.
- Back-to-back: `start` held high is accepted at the first edge in IDLE after DONE. Minimum period is ROWS+5+OP_LAT cycles.
- ROWS=1 is legal: one read, one write, and `done` in cycle 5+OP_LAT.

## Test plan
- Defaults, with a negating registered operator model (OP_LAT=1):
  - Stimulus: source row0=0x0102030405, row1..4 = 0x7F80FF0001, start pulse.
  - Required:
    - dst row0=0xFFFEFDFCFB.
    - dst rows1..4=0x818001 00FF, i.e. 0x81_80_01_00_FF, per-element negation with 0x80 wrapping.
    - 5 writes in cycles 5..9, `done` at cycle 10.
- Start while busy: pulse `start` again in cycle 3 and cycle 10 (DONE). Required: ignored, exactly 5 writes, no second operation.
- Reset mid-run: assert `rst_n`=0 in cycle 6.
  - Required: all outputs 0 that cycle, no writes after cycle 6, `done` never pulses.
  - A new start after release produces a full 5-row operation.
- OP_LAT=3, ROWS=5 with identity operator: writes in cycles 7..11, data equal to source, `done` cycle 12, `busy` 1..11.
- ROWS=1: single read cycle 1, write cycle 5 (OP_LAT=1), `done` cycle 6.
- Back-to-back with `start` held high: second operation's first `src_rd` is at cycle 12. Total 10 writes, with addresses 0..4 twice.

Source files
------------

// File: rtl/matrix_row_sequencer_if.sv
// rtl/matrix_row_sequencer_if.sv - bus bundle between the row sequencer and its buffers/operator
//
// Signals (direction as seen from the sequencer, modport master):
//   start      in   begin an operation (sampled only while idle)
//   src_rd     out  source buffer read strobe
//   src_addr   out  source row index
//   src_rdata  in   source row, valid the cycle after src_rd
//   op_row     out  registered row presented to the operator
//   op_res     in   operator result row
//   dst_we     out  destination write strobe
//   dst_addr   out  destination row index
//   dst_wdata  out  destination row data
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
// The slave modport is the environment side (buffers, operator, host).
interface matrix_row_sequencer_if #(
    parameter int ROW_W = 40
);
    logic             start;
    logic             src_rd;
    logic [2:0]       src_addr;
    logic [ROW_W-1:0] src_rdata;
    logic [ROW_W-1:0] op_row;
    logic [ROW_W-1:0] op_res;
    logic             dst_we;
    logic [2:0]       dst_addr;
    logic [ROW_W-1:0] dst_wdata;
    logic             busy;
    logic             done;

    modport master (
        input  start,
        input  src_rdata,
        input  op_res,
        output src_rd,
        output src_addr,
        output op_row,
        output dst_we,
        output dst_addr,
        output dst_wdata,
        output busy,
        output done
    );

    modport slave (
        output start,
        output src_rdata,
        output op_res,
        input  src_rd,
        input  src_addr,
        input  op_row,
        input  dst_we,
        input  dst_addr,
        input  dst_wdata,
        input  busy,
        input  done
    );
endinterface

// File: rtl/matrix_row_sequencer.sv
// rtl/matrix_row_sequencer.sv - streams matrix rows source -> row operator -> destination
//
// Parameters: ROWS (1..8) rows per operation, ROW_W packed row width,
//             OP_LAT (1..4) cycles from op_row change to matching op_res.
// Ports: clk, rst_n (asynchronous, active low) and bus
//        (matrix_row_sequencer_if.master: start, source read port, operator
//        row/result, destination write port, busy, done).
module matrix_row_sequencer #(
    parameter int ROWS   = 5,
    parameter int ROW_W  = 40,
    parameter int OP_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    matrix_row_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAST = 3'(ROWS - 1);

    state_t           state;
    logic             src_rd;
    logic [2:0]       src_addr;
    logic             busy;
    logic             done;

    // Tag pipeline: valid bit + row index following each row from read
    // issue, through op_row capture, across the operator latency.
    logic             rd_v;
    logic [2:0]       rd_idx;
    logic             op_v;
    logic [2:0]       op_idx;
    logic [ROW_W-1:0] op_row;
    logic [OP_LAT-1:0] lat_v;
    logic [2:0]       lat_idx [OP_LAT];

    logic             dst_we;
    logic [2:0]       dst_addr;
    logic [ROW_W-1:0] dst_wdata;

    assign bus.src_rd    = src_rd;
    assign bus.src_addr  = src_addr;
    assign bus.op_row    = op_row;
    assign bus.dst_we    = dst_we;
    assign bus.dst_addr  = dst_addr;
    assign bus.dst_wdata = dst_wdata;
    assign bus.busy      = busy;
    assign bus.done      = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_rd   <= 1'b0;
            src_addr <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        state    <= ISSUE;
                        src_rd   <= 1'b1;
                        src_addr <= 3'd0;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (src_addr == LAST) begin
                        src_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        src_addr <= src_addr + 3'd1;
                    end
                end
                DRAIN: begin
                    // The last row's write strobe is being presented this
                    // cycle, so done lands on the following cycle.
                    if (dst_we && dst_addr == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v      <= 1'b0;
            rd_idx    <= 3'd0;
            op_v      <= 1'b0;
            op_idx    <= 3'd0;
            op_row    <= '0;
            lat_v     <= '0;
            for (int k = 0; k < OP_LAT; k++) begin
                lat_idx[k] <= 3'd0;
            end
            dst_we    <= 1'b0;
            dst_addr  <= 3'd0;
            dst_wdata <= '0;
        end else begin
            // Synchronous source memory: data for a read issued this cycle
            // arrives next cycle, when rd_v marks it.
            rd_v   <= src_rd;
            rd_idx <= src_addr;
            op_v   <= rd_v;
            op_idx <= rd_idx;
            if (rd_v) begin
                op_row <= bus.src_rdata;
            end

            lat_v[0]   <= op_v;
            lat_idx[0] <= op_idx;
            for (int k = 1; k < OP_LAT; k++) begin
                lat_v[k]   <= lat_v[k-1];
                lat_idx[k] <= lat_idx[k-1];
            end

            // op_res matches the tag at the end of the latency chain.
            dst_we <= lat_v[OP_LAT-1];
            if (lat_v[OP_LAT-1]) begin
                dst_addr  <= lat_idx[OP_LAT-1];
                dst_wdata <= bus.op_res;
            end
        end
    end

endmodule

// File: tb/tb_matrix_row_sequencer.sv
// tb/tb_matrix_row_sequencer.sv - directed self-checking bench for matrix_row_sequencer
module tb_matrix_row_sequencer;

    localparam int ROW_W = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    matrix_row_sequencer_if #(.ROW_W(ROW_W)) if0 ();
    matrix_row_sequencer_if #(.ROW_W(ROW_W)) if1 ();
    matrix_row_sequencer_if #(.ROW_W(ROW_W)) if2 ();

    matrix_row_sequencer #(.ROWS(5), .ROW_W(ROW_W), .OP_LAT(1)) u_def (
        .clk(clk), .rst_n(rst_n), .bus(if0.master));
    matrix_row_sequencer #(.ROWS(5), .ROW_W(ROW_W), .OP_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master));
    matrix_row_sequencer #(.ROWS(1), .ROW_W(ROW_W), .OP_LAT(1)) u_one (
        .clk(clk), .rst_n(rst_n), .bus(if2.master));

    logic [ROW_W-1:0] src_mem [8];
    logic [ROW_W-1:0] src_tab [5];
    logic [ROW_W-1:0] exp_neg [5];

    function automatic logic [ROW_W-1:0] neg_row(logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        for (int k = 0; k < 5; k++) begin
            o[k*8 +: 8] = 8'(~r[k*8 +: 8] + 8'd1);
        end
        return o;
    endfunction

    // Source buffers (1-cycle synchronous read) and operator models.
    always @(posedge clk) if (if0.src_rd) if0.src_rdata <= src_mem[if0.src_addr];
    always @(posedge clk) if (if1.src_rd) if1.src_rdata <= src_mem[if1.src_addr];
    always @(posedge clk) if (if2.src_rd) if2.src_rdata <= src_mem[if2.src_addr];

    logic [ROW_W-1:0] d1, d2;
    always @(posedge clk) if0.op_res <= neg_row(if0.op_row);
    always @(posedge clk) begin
        d1 <= if1.op_row;
        d2 <= d1;
        if1.op_res <= d2;
    end
    always @(posedge clk) if2.op_res <= neg_row(if2.op_row);

    int sel;
    logic             s_src_rd, s_dst_we, s_busy, s_done;
    logic [2:0]       s_src_addr, s_dst_addr;
    logic [ROW_W-1:0] s_op_row, s_dst_wdata;

    always_comb begin
        s_src_rd = if0.src_rd; s_src_addr = if0.src_addr; s_op_row = if0.op_row;
        s_dst_we = if0.dst_we; s_dst_addr = if0.dst_addr; s_dst_wdata = if0.dst_wdata;
        s_busy = if0.busy; s_done = if0.done;
        if (sel == 1) begin
            s_src_rd = if1.src_rd; s_src_addr = if1.src_addr; s_op_row = if1.op_row;
            s_dst_we = if1.dst_we; s_dst_addr = if1.dst_addr; s_dst_wdata = if1.dst_wdata;
            s_busy = if1.busy; s_done = if1.done;
        end else if (sel == 2) begin
            s_src_rd = if2.src_rd; s_src_addr = if2.src_addr; s_op_row = if2.op_row;
            s_dst_we = if2.dst_we; s_dst_addr = if2.dst_addr; s_dst_wdata = if2.dst_wdata;
            s_busy = if2.busy; s_done = if2.done;
        end
    end

    // Destination buffer and event counters for the selected instance.
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [ROW_W-1:0] dst_mem [8];
    always @(posedge clk) begin
        if (s_dst_we) begin
            wr_cnt <= wr_cnt + 1;
            dst_mem[s_dst_addr] <= s_dst_wdata;
        end
        if (s_done) done_cnt <= done_cnt + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic set_start(int s, logic v);
        case (s)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic chk_cleared(string tag);
        chk({tag, " src_rd"},    64'(s_src_rd),    64'd0);
        chk({tag, " src_addr"},  64'(s_src_addr),  64'd0);
        chk({tag, " op_row"},    64'(s_op_row),    64'd0);
        chk({tag, " dst_we"},    64'(s_dst_we),    64'd0);
        chk({tag, " dst_addr"},  64'(s_dst_addr),  64'd0);
        chk({tag, " dst_wdata"}, 64'(s_dst_wdata), 64'd0);
        chk({tag, " busy"},      64'(s_busy),      64'd0);
        chk({tag, " done"},      64'(s_done),      64'd0);
    endtask

    function automatic logic [ROW_W-1:0] exp_row(int i, bit neg);
        return neg ? exp_neg[i] : src_tab[i];
    endfunction

    // One (or two back-to-back) operations; start is raised at edge 0, c is
    // the cycle number after that edge. r1/r2 pulse start in those cycles.
    task automatic run_op(int s, int rows, int lat, bit neg, int nops, int r1, int r2, string name);
        int period, last_c, wr0, dn0, cc;
        bit rd_e, we_e;
        period = rows + 5 + lat;
        last_c = nops * period + 2;
        sel = s;
        @(negedge clk);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        set_start(s, 1'b1);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            set_start(s, (nops == 2 && c <= period) || c == r1 || c == r2);
            cc = (nops == 2 && c > period) ? c - period : c;
            rd_e = (cc >= 1 && cc <= rows);
            we_e = (cc >= 4 + lat && cc <= rows + 3 + lat);
            chk($sformatf("%s c%0d src_rd", name, c), 64'(s_src_rd), 64'(rd_e));
            if (rd_e) chk($sformatf("%s c%0d src_addr", name, c), 64'(s_src_addr), 64'(cc - 1));
            chk($sformatf("%s c%0d dst_we", name, c), 64'(s_dst_we), 64'(we_e));
            if (we_e) begin
                chk($sformatf("%s c%0d dst_addr", name, c), 64'(s_dst_addr), 64'(cc - 4 - lat));
                chk($sformatf("%s c%0d dst_wdata", name, c), 64'(s_dst_wdata),
                    64'(exp_row(cc - 4 - lat, neg)));
            end
            chk($sformatf("%s c%0d busy", name, c), 64'(s_busy), 64'(cc <= rows + 3 + lat));
            chk($sformatf("%s c%0d done", name, c), 64'(s_done), 64'(cc == rows + 4 + lat));
            if (cc >= 3 && cc <= rows + 2)
                chk($sformatf("%s c%0d op_row", name, c), 64'(s_op_row), 64'(src_tab[cc - 3]));
            else if (cc > rows + 2)
                chk($sformatf("%s c%0d op_row hold", name, c), 64'(s_op_row), 64'(src_tab[rows - 1]));
        end
        chk({name, " write count"}, 64'(wr_cnt - wr0), 64'(nops * rows));
        chk({name, " done count"}, 64'(done_cnt - dn0), 64'(nops));
        for (int i = 0; i < rows; i++)
            chk($sformatf("%s dst row%0d", name, i), 64'(dst_mem[i]), 64'(exp_row(i, neg)));
    endtask

    initial begin
        int wr0, dn0;
        src_tab[0] = 40'h01_02_03_04_05;
        for (int i = 1; i < 5; i++) src_tab[i] = 40'h7F_80_FF_00_01;
        exp_neg[0] = 40'hFF_FE_FD_FC_FB;
        for (int i = 1; i < 5; i++) exp_neg[i] = 40'h81_80_01_00_FF;
        for (int i = 0; i < 8; i++) src_mem[i] = (i < 5) ? src_tab[i] : '0;
        sel = 0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(0, 5, 1, 1'b1, 1, 3, 10, "def");

        // Reset asserted in cycle 6: only row 0 (cycle 5) gets written.
        sel = 0;
        @(negedge clk);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_cleared("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst writes", 64'(wr_cnt - wr0), 64'd1);
        chk("midrst done", 64'(done_cnt - dn0), 64'd0);
        chk("midrst idle busy", 64'(s_busy), 64'd0);
        chk("midrst idle src_rd", 64'(s_src_rd), 64'd0);
        run_op(0, 5, 1, 1'b1, 1, 0, 0, "rerun");

        run_op(1, 5, 3, 1'b0, 1, 0, 0, "lat3");
        run_op(2, 1, 1, 1'b1, 1, 0, 0, "rows1");
        run_op(0, 5, 1, 1'b1, 2, 0, 0, "b2b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
